// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - single-outstanding instruction fetch stage with stall, redirect and squash
module fetch_stage #(
    parameter int                AWIDTH   = 32,
    parameter int                DWIDTH   = 32,
    parameter logic [AWIDTH-1:0] BASEADDR = 32'h0100_0000
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req_o,
    output logic [AWIDTH-1:0] imem_addr_o,
    input  logic              imem_ready_i,
    input  logic              imem_rvalid_i,
    input  logic [DWIDTH-1:0] imem_rdata_i,
    input  logic              stall_i,
    input  logic              redirect_i,
    input  logic [AWIDTH-1:0] redirect_pc_i,
    output logic [DWIDTH-1:0] insn_o,
    output logic [AWIDTH-1:0] pc_o,
    output logic [AWIDTH-1:0] pc_plus4_o,
    output logic              valid_o
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        OUT   = 2'd2,
        DROP  = 2'd3
    } state_t;

    localparam logic [DWIDTH-1:0] NOP  = DWIDTH'(32'h0000_0013);
    localparam logic [AWIDTH-1:0] FOUR = AWIDTH'(4);

    state_t            state;
    logic [AWIDTH-1:0] pc_q;
    logic [AWIDTH-1:0] redirect_aligned;

    assign redirect_aligned = {redirect_pc_i[AWIDTH-1:2], 2'b00};

    // A redirect suppresses the request in the same cycle so a stale address is never accepted.
    assign imem_req_o  = (state == FETCH) && !reset && !redirect_i;
    assign imem_addr_o = pc_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= FETCH;
            pc_q       <= BASEADDR;
            valid_o    <= 1'b0;
            insn_o     <= NOP;
            pc_o       <= BASEADDR;
            pc_plus4_o <= BASEADDR + FOUR;
        end else if (redirect_i) begin
            pc_q    <= redirect_aligned;
            valid_o <= 1'b0;
            case (state)
                FETCH:   state <= FETCH;
                WAIT:    state <= imem_rvalid_i ? FETCH : DROP;
                OUT:     state <= FETCH;
                default: state <= DROP;
            endcase
        end else begin
            case (state)
                FETCH: begin
                    if (imem_ready_i) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rvalid_i) begin
                        insn_o     <= imem_rdata_i;
                        pc_o       <= pc_q;
                        pc_plus4_o <= pc_q + FOUR;
                        valid_o    <= 1'b1;
                        pc_q       <= pc_q + FOUR;
                        state      <= OUT;
                    end
                end
                OUT: begin
                    if (!stall_i) begin
                        valid_o <= 1'b0;
                        state   <= FETCH;
                    end
                end
                default: begin
                    // Squashed response: discard and resume at the redirected PC.
                    if (imem_rvalid_i) begin
                        state <= FETCH;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed self-checking bench for fetch_stage
module tb_fetch_stage;

    localparam logic [31:0] BASE = 32'h0100_0000;
    localparam logic [31:0] NOP  = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ready_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic [31:0] insn_o;
    logic [31:0] pc_o;
    logic [31:0] pc_plus4_o;
    logic        valid_o;

    int errors = 0;
    int checks = 0;

    fetch_stage #(
        .AWIDTH(32),
        .DWIDTH(32),
        .BASEADDR(32'h0100_0000)
    ) dut (
        .clk(clk),
        .reset(reset),
        .imem_req_o(imem_req_o),
        .imem_addr_o(imem_addr_o),
        .imem_ready_i(imem_ready_i),
        .imem_rvalid_i(imem_rvalid_i),
        .imem_rdata_i(imem_rdata_i),
        .stall_i(stall_i),
        .redirect_i(redirect_i),
        .redirect_pc_i(redirect_pc_i),
        .insn_o(insn_o),
        .pc_o(pc_o),
        .pc_plus4_o(pc_plus4_o),
        .valid_o(valid_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_valid"}, {31'd0, valid_o}, 32'd0);
        chk({tag, "_insn"}, insn_o, NOP);
        chk({tag, "_pc"}, pc_o, BASE);
        chk({tag, "_pc4"}, pc_plus4_o, BASE + 32'd4);
    endtask

    initial begin
        reset = 1'b1;
        imem_ready_i = 1'b1;
        imem_rvalid_i = 1'b0;
        imem_rdata_i = 32'h0;
        stall_i = 1'b0;
        redirect_i = 1'b0;
        redirect_pc_i = 32'h0;
        tick();
        tick();
        chk("rst_req", {31'd0, imem_req_o}, 32'd0);
        chk_reset_outputs("rst");

        // Basic fetch with 1-cycle latency
        reset = 1'b0;
        settle();
        chk("f1_req", {31'd0, imem_req_o}, 32'd1);
        chk("f1_addr", imem_addr_o, BASE);
        tick();
        imem_ready_i = 1'b0;
        settle();
        chk("f1_wait_req", {31'd0, imem_req_o}, 32'd0);
        imem_rvalid_i = 1'b1;
        imem_rdata_i = 32'h0050_0093;
        stall_i = 1'b1;
        tick();
        imem_rvalid_i = 1'b0;
        chk("f1_valid", {31'd0, valid_o}, 32'd1);
        chk("f1_insn", insn_o, 32'h0050_0093);
        chk("f1_pc", pc_o, 32'h0100_0000);
        chk("f1_pc4", pc_plus4_o, 32'h0100_0004);

        // Stall hold in OUT
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("stall_valid", {31'd0, valid_o}, 32'd1);
            chk("stall_insn", insn_o, 32'h0050_0093);
            chk("stall_pc", pc_o, 32'h0100_0000);
            chk("stall_req", {31'd0, imem_req_o}, 32'd0);
        end
        stall_i = 1'b0;
        tick();
        chk("rel_valid", {31'd0, valid_o}, 32'd0);
        chk("rel_req", {31'd0, imem_req_o}, 32'd1);
        chk("rel_addr", imem_addr_o, 32'h0100_0004);

        // Redirect in WAIT before the response
        imem_ready_i = 1'b1;
        tick();
        imem_ready_i = 1'b0;
        redirect_i = 1'b1;
        redirect_pc_i = 32'h0100_0040;
        tick();
        redirect_i = 1'b0;
        settle();
        chk("drop_req0", {31'd0, imem_req_o}, 32'd0);
        chk("drop_valid0", {31'd0, valid_o}, 32'd0);
        tick();
        chk("drop_req1", {31'd0, imem_req_o}, 32'd0);
        imem_rvalid_i = 1'b1;
        imem_rdata_i = 32'hDEAD_BEEF;
        tick();
        imem_rvalid_i = 1'b0;
        chk("drop_valid", {31'd0, valid_o}, 32'd0);
        chk("drop_insn_kept", insn_o, 32'h0050_0093);
        chk("drop_req", {31'd0, imem_req_o}, 32'd1);
        chk("drop_addr", imem_addr_o, 32'h0100_0040);

        // Redirect coincident with rvalid in WAIT, unaligned target
        imem_ready_i = 1'b1;
        tick();
        imem_ready_i = 1'b0;
        imem_rvalid_i = 1'b1;
        imem_rdata_i = 32'h1234_5678;
        redirect_i = 1'b1;
        redirect_pc_i = 32'h0100_0083;
        tick();
        imem_rvalid_i = 1'b0;
        redirect_i = 1'b0;
        settle();
        chk("coin_valid", {31'd0, valid_o}, 32'd0);
        chk("coin_insn_kept", insn_o, 32'h0050_0093);
        chk("coin_req", {31'd0, imem_req_o}, 32'd1);
        chk("coin_addr", imem_addr_o, 32'h0100_0080);

        // Backpressure: memory not ready for 3 cycles
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_req", {31'd0, imem_req_o}, 32'd1);
            chk("bp_addr", imem_addr_o, 32'h0100_0080);
        end
        imem_ready_i = 1'b1;
        tick();
        imem_ready_i = 1'b0;
        imem_rvalid_i = 1'b1;
        imem_rdata_i = 32'h00A0_0113;
        tick();
        imem_rvalid_i = 1'b0;
        chk("bp_valid", {31'd0, valid_o}, 32'd1);
        chk("bp_insn", insn_o, 32'h00A0_0113);
        chk("bp_pc", pc_o, 32'h0100_0080);
        chk("bp_pc4", pc_plus4_o, 32'h0100_0084);

        // Redirect in OUT while stalled flushes the output
        stall_i = 1'b1;
        redirect_i = 1'b1;
        redirect_pc_i = 32'h0100_0100;
        tick();
        redirect_i = 1'b0;
        stall_i = 1'b0;
        settle();
        chk("rout_valid", {31'd0, valid_o}, 32'd0);
        chk("rout_insn_kept", insn_o, 32'h00A0_0113);
        chk("rout_req", {31'd0, imem_req_o}, 32'd1);
        chk("rout_addr", imem_addr_o, 32'h0100_0100);

        // Reset asserted in WAIT, then a late response in FETCH
        imem_ready_i = 1'b1;
        tick();
        imem_ready_i = 1'b0;
        reset = 1'b1;
        tick();
        chk("rw_req", {31'd0, imem_req_o}, 32'd0);
        chk_reset_outputs("rw");
        reset = 1'b0;
        settle();
        chk("rw_req_after", {31'd0, imem_req_o}, 32'd1);
        chk("rw_addr", imem_addr_o, BASE);
        imem_rvalid_i = 1'b1;
        imem_rdata_i = 32'hFFFF_FFFF;
        tick();
        imem_rvalid_i = 1'b0;
        chk("late_valid", {31'd0, valid_o}, 32'd0);
        chk("late_insn", insn_o, NOP);
        chk("late_req", {31'd0, imem_req_o}, 32'd1);
        chk("late_addr", imem_addr_o, BASE);

        // Reset asserted in DROP
        imem_ready_i = 1'b1;
        tick();
        imem_ready_i = 1'b0;
        redirect_i = 1'b1;
        redirect_pc_i = 32'h0100_0200;
        tick();
        redirect_i = 1'b0;
        settle();
        chk("rd_drop_req", {31'd0, imem_req_o}, 32'd0);
        reset = 1'b1;
        tick();
        chk("rd_req", {31'd0, imem_req_o}, 32'd0);
        chk_reset_outputs("rd");
        reset = 1'b0;
        settle();
        chk("rd_req_after", {31'd0, imem_req_o}, 32'd1);
        chk("rd_addr", imem_addr_o, BASE);

        // Redirect in FETCH masks the request; PC wraps past the top of memory
        redirect_i = 1'b1;
        redirect_pc_i = 32'hFFFF_FFFE;
        settle();
        chk("rf_req_masked", {31'd0, imem_req_o}, 32'd0);
        tick();
        redirect_i = 1'b0;
        settle();
        chk("wrap_addr", imem_addr_o, 32'hFFFF_FFFC);
        imem_ready_i = 1'b1;
        tick();
        imem_ready_i = 1'b0;
        imem_rvalid_i = 1'b1;
        imem_rdata_i = 32'h0000_006F;
        tick();
        imem_rvalid_i = 1'b0;
        chk("wrap_insn", insn_o, 32'h0000_006F);
        chk("wrap_pc", pc_o, 32'hFFFF_FFFC);
        chk("wrap_pc4", pc_plus4_o, 32'h0000_0000);
        tick();
        chk("wrap_next_valid", {31'd0, valid_o}, 32'd0);
        chk("wrap_next_addr", imem_addr_o, 32'h0000_0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
